cpu_ctrl_fsm: RTL and testbench

CPU_CTRL_FSM -- requirements
Module: cpu_ctrl_fsm

---
 rtl/cpu_ctrl_pkg.sv | 41 ++++
 rtl/cpu_op_decode.sv | 40 ++++
 rtl/cpu_ctrl_fsm.sv | 136 +++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: WISC opcode and controller state encodings shared by the control FSM.
// Rev 1.0
`default_nettype none

package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'b0000,
        OP_SUB    = 4'b0001,
        OP_RED    = 4'b0010,
        OP_XOR    = 4'b0011,
        OP_SLL    = 4'b0100,
        OP_SRA    = 4'b0101,
        OP_ROR    = 4'b0110,
        OP_PADDSB = 4'b0111,
        OP_LW     = 4'b1000,
        OP_SW     = 4'b1001,
        OP_LLB    = 4'b1010,
        OP_LHB    = 4'b1011,
        OP_B      = 4'b1100,
        OP_BR     = 4'b1101,
        OP_PCS    = 4'b1110,
        OP_HLT    = 4'b1111
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC2 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/cpu_op_decode.sv
// cpu_op_decode: combinational opcode-to-instruction-class decoder.
// Rev 1.0
`default_nettype none

module cpu_op_decode
    import cpu_ctrl_pkg::*;
(
    input  opcode_e opcode,
    output logic    is_alu,
    output logic    sets_flags,
    output logic    is_mem,
    output logic    is_branch,
    output logic    is_pcs,
    output logic    is_hlt
);

    always_comb begin
        is_alu     = 1'b0;
        sets_flags = 1'b0;
        is_mem     = 1'b0;
        is_branch  = 1'b0;
        is_pcs     = 1'b0;
        is_hlt     = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB, OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                is_alu     = 1'b1;
                sets_flags = 1'b1;
            end
            OP_RED, OP_PADDSB, OP_LLB, OP_LHB: is_alu    = 1'b1;
            OP_LW, OP_SW:                      is_mem    = 1'b1;
            OP_B, OP_BR:                       is_branch = 1'b1;
            OP_PCS:                            is_pcs    = 1'b1;
            OP_HLT:                            is_hlt    = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle WISC control FSM (FETCH/DECODE/EXEC/MEM/WB/HALT).
// Rev 1.0 -- optional stall counter output enabled by CPU_CTRL_STALL_CNT_EN.
`default_nettype none

module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        flag_we,
    output logic [1:0]  wb_sel,
    output logic        hlt,
    output logic [2:0]  state
`ifdef CPU_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    state_e  cur_state;
    state_e  nxt_state;
    opcode_e op_q;
    opcode_e dec_op;
    logic    is_alu;
    logic    sets_flags;
    logic    is_mem;
    logic    is_branch;
    logic    is_pcs;
    logic    is_hlt;

    // The live IR opcode is only consulted in DECODE; every later state uses the latched copy.
    assign dec_op = (cur_state == S_DECODE) ? opcode_e'(opcode) : op_q;

    cpu_op_decode u_dec (
        .opcode     (dec_op),
        .is_alu     (is_alu),
        .sets_flags (sets_flags),
        .is_mem     (is_mem),
        .is_branch  (is_branch),
        .is_pcs     (is_pcs),
        .is_hlt     (is_hlt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
            op_q      <= OP_ADD;
        end else begin
            cur_state <= nxt_state;
            if (cur_state == S_DECODE) begin
                op_q <= opcode_e'(opcode);
            end
        end
    end

    always_comb begin
        nxt_state = cur_state;
        pc_we     = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        flag_we   = 1'b0;
        wb_sel    = WB_ALU;
        hlt       = 1'b0;
        // Outputs are held low for as long as reset is asserted, not just after the next edge.
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        nxt_state = S_DECODE;
                    end
                end
                S_DECODE: nxt_state = is_hlt ? S_HALT : S_EXEC;
                S_EXEC: begin
                    flag_we = sets_flags;
                    if (is_mem) begin
                        nxt_state = S_MEM;
                    end else if (is_branch) begin
                        pc_we     = branch_taken;
                        nxt_state = S_FETCH;
                    end else if (is_alu || is_pcs) begin
                        nxt_state = S_WB;
                    end else begin
                        nxt_state = S_FETCH;
                    end
                end
                S_MEM: begin
                    mem_re = (op_q == OP_LW);
                    mem_we = (op_q != OP_LW);
                    if (mem_ready) begin
                        nxt_state = (op_q == OP_LW) ? S_WB : S_FETCH;
                    end
                end
                S_WB: begin
                    reg_we    = 1'b1;
                    nxt_state = S_FETCH;
                    if (op_q == OP_LW) begin
                        wb_sel = WB_MEM;
                    end else if (op_q == OP_PCS) begin
                        wb_sel = WB_PC2;
                    end
                end
                S_HALT: hlt = 1'b1;
                default: nxt_state = S_FETCH;
            endcase
        end
    end

    assign state = cur_state;

`ifdef CPU_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if ((cur_state == S_FETCH || cur_state == S_MEM) && !mem_ready
                     && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: randomized instruction-level stimulus with a queued per-cycle scoreboard.
// Rev 1.0
`default_nettype none

module tb_cpu_ctrl_fsm;
    import cpu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_we, ir_we, reg_we, mem_re, mem_we, flag_we, hlt;
    logic [1:0]  wb_sel;
    logic [2:0]  state;
`ifdef CPU_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    cpu_ctrl_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ir_we        (ir_we),
        .reg_we       (reg_we),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .flag_we      (flag_we),
        .wb_sel       (wb_sel),
        .hlt          (hlt),
        .state        (state)
`ifdef CPU_CTRL_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] v;
        int          stall;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   stalls = 0;
    event chk_now;

    function automatic logic [11:0] pk(state_e s, logic h, logic [1:0] wb, logic fw,
                                       logic mw, logic mr, logic rw, logic iw, logic pw);
        return {s, h, wb, fw, mw, mr, rw, iw, pw};
    endfunction

    // Monitor: compares one queued expectation per sample point.
    initial begin
        exp_t        e;
        logic [11:0] got;
        forever begin
            @(negedge clk or chk_now);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {state, hlt, wb_sel, flag_we, mem_we, mem_re, reg_we, ir_we, pc_we};
                checks++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s outputs {state,hlt,wb_sel,flag,mwe,mre,rwe,irwe,pcwe} got=%b want=%b @%0t",
                             e.tag, got, e.v, $time);
                end
`ifdef CPU_CTRL_STALL_CNT_EN
                checks++;
                if (stall_cnt !== 16'(e.stall)) begin
                    errors++;
                    $display("FAIL %s stall_cnt got=%0d want=%0d @%0t", e.tag, stall_cnt, e.stall, $time);
                end
`endif
            end
        end
    end

    task automatic push(input logic [11:0] v, input string tag);
        exp_t e;
        e.v     = v;
        e.stall = (stalls > 65535) ? 65535 : stalls;
        e.tag   = tag;
        q.push_back(e);
    endtask

    // One clock cycle: drive inputs, queue expectation, advance to just after the next edge.
    task automatic cyc(input logic [3:0] op_in, input logic rdy, input logic tk,
                       input logic [11:0] ev, input string tag, input bit stall_cycle);
        opcode       = op_in;
        mem_ready    = rdy;
        branch_taken = tk;
        push(ev, tag);
        if (stall_cycle) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        stalls    = 0;
        #1;
        push(pk(S_FETCH, 0, 2'd0, 0, 0, 0, 0, 0, 0), "reset_async");
        -> chk_now;
        @(posedge clk);
        #1;
        push(pk(S_FETCH, 0, 2'd0, 0, 0, 0, 0, 0, 0), "reset_held");
        -> chk_now;
        #1;
        rst_n = 1'b1;
    endtask

    // Instruction-level model: expected cycle sequence derived from the opcode class.
    task automatic run_instr(input logic [3:0] op, input logic tk, input int fs, input int ms,
                             input bit stop_in_mem);
        bit         fl, br, lw, sw;
        logic [1:0] wb;
        fl = (op inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6});
        br = (op inside {4'hC, 4'hD});
        lw = (op == 4'h8);
        sw = (op == 4'h9);
        wb = lw ? 2'd1 : (op == 4'hE) ? 2'd2 : 2'd0;
        for (int i = 0; i < fs; i++)
            cyc(4'($urandom), 1'b0, 1'($urandom), pk(S_FETCH, 0, 2'd0, 0, 0, 1, 0, 0, 0), "fetch_stall", 1);
        cyc(4'($urandom), 1'b1, 1'($urandom), pk(S_FETCH, 0, 2'd0, 0, 0, 1, 0, 1, 1), "fetch", 0);
        cyc(op, 1'($urandom), 1'($urandom), pk(S_DECODE, 0, 2'd0, 0, 0, 0, 0, 0, 0), "decode", 0);
        if (op == 4'hF) return;
        cyc(4'($urandom), 1'($urandom), tk, pk(S_EXEC, 0, 2'd0, fl, 0, 0, 0, 0, br & tk), "exec", 0);
        if (lw || sw) begin
            for (int i = 0; i < ms; i++) begin
                cyc(4'($urandom), 1'b0, 1'($urandom), pk(S_MEM, 0, 2'd0, 0, sw, lw, 0, 0, 0), "mem_stall", 1);
                if (stop_in_mem) return;
            end
            cyc(4'($urandom), 1'b1, 1'($urandom), pk(S_MEM, 0, 2'd0, 0, sw, lw, 0, 0, 0), "mem_done", 0);
        end
        if (!br && !sw)
            cyc(4'($urandom), 1'($urandom), 1'($urandom), pk(S_WB, 0, wb, 0, 0, 0, 1, 0, 0), "wb", 0);
    endtask

    initial begin
        #2;
        push(pk(S_FETCH, 0, 2'd0, 0, 0, 0, 0, 0, 0), "reset_initial");
        -> chk_now;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stalls = 0;

        run_instr(4'h0, 1'b0, 0, 0, 0);             // ADD, no stalls
        run_instr(4'h8, 1'b0, 0, 3, 0);             // LW, 3 memory stalls
        run_instr(4'hC, 1'b1, 0, 0, 0);             // B taken
        run_instr(4'hC, 1'b0, 0, 0, 0);             // B not taken
        run_instr(4'hE, 1'b0, 1, 0, 0);             // PCS
        run_instr(4'h9, 1'b0, 0, 2, 0);             // SW

        for (int n = 0; n < 80; n++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom), $urandom_range(0, 2),
                      $urandom_range(0, 3), 0);

        run_instr(4'h9, 1'b0, 0, 2, 1);             // SW interrupted by reset in MEM
        do_reset();
        run_instr(4'h1, 1'b0, 0, 0, 0);

        run_instr(4'hF, 1'b0, 0, 0, 0);             // HLT
        for (int i = 0; i < 20; i++)
            cyc(4'($urandom), 1'($urandom), 1'($urandom), pk(S_HALT, 1, 2'd0, 0, 0, 0, 0, 0, 0), "halt", 0);
        do_reset();

`ifdef CPU_CTRL_STALL_CNT_EN
        for (int i = 0; i < 70000; i++)
            cyc(4'($urandom), 1'b0, 1'($urandom), pk(S_FETCH, 0, 2'd0, 0, 0, 1, 0, 0, 0), "stall_sat", 1);
`endif
        run_instr(4'h3, 1'b0, 0, 0, 0);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain queue got=%0d pending want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
